// File: rtl/hid_kbd_scancode_pkg.sv
// Shared constants, state/report types and the HID usage -> PS/2 set-2 lookup
// used by the hid_kbd_scancode translator.
package hid_kbd_pkg;

  localparam int MOD_BYTE       = 0;
  localparam int RSVD_BYTE      = 1;
  localparam int FIRST_KEY_BYTE = 2;
  localparam int NUM_KEY_SLOTS  = 6;

  localparam logic [7:0] PS2_EXT            = 8'hE0;
  localparam logic [7:0] PS2_BRK            = 8'hF0;
  localparam logic [7:0] USAGE_ERR_ROLLOVER = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MOD,
    ST_BRK,
    ST_MK,
    ST_COMMIT,
    ST_REP
  } kbd_state_e;

  // Reserved byte is not stored; keys[0] is report byte 2.
  typedef struct packed {
    logic [NUM_KEY_SLOTS-1:0][7:0] keys;
    logic [7:0]                    mods;
  } kbd_rpt_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  function automatic kbd_rpt_t unpack_report(input logic [63:0] raw);
    kbd_rpt_t r;
    r.mods = raw[8*MOD_BYTE +: 8];
    r.keys = raw[63:8*FIRST_KEY_BYTE];
    return r;
  endfunction

  function automatic logic usage_in_report(input logic [7:0] usage, input kbd_rpt_t rpt);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_KEY_SLOTS; i++) begin
      if (rpt.keys[i] == usage) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic ps2_key_t modifier_to_ps2(input logic [2:0] bit_idx);
    ps2_key_t k;
    case (bit_idx)
      3'd0:    k = 9'h0_14;  // LCtrl
      3'd1:    k = 9'h0_12;  // LShift
      3'd2:    k = 9'h0_11;  // LAlt
      3'd3:    k = 9'h1_1F;  // LGUI
      3'd4:    k = 9'h1_14;  // RCtrl
      3'd5:    k = 9'h0_59;  // RShift
      3'd6:    k = 9'h1_11;  // RAlt
      default: k = 9'h1_27;  // RGUI
    endcase
    return k;
  endfunction

  // Code 8'h00 marks a usage without a set-2 equivalent.
  function automatic ps2_key_t usage_to_ps2(input logic [7:0] usage);
    ps2_key_t k;
    case (usage)
      8'h04: k = 9'h0_1C;  8'h05: k = 9'h0_32;  8'h06: k = 9'h0_21;  8'h07: k = 9'h0_23;
      8'h08: k = 9'h0_24;  8'h09: k = 9'h0_2B;  8'h0A: k = 9'h0_34;  8'h0B: k = 9'h0_33;
      8'h0C: k = 9'h0_43;  8'h0D: k = 9'h0_3B;  8'h0E: k = 9'h0_42;  8'h0F: k = 9'h0_4B;
      8'h10: k = 9'h0_3A;  8'h11: k = 9'h0_31;  8'h12: k = 9'h0_44;  8'h13: k = 9'h0_4D;
      8'h14: k = 9'h0_15;  8'h15: k = 9'h0_2D;  8'h16: k = 9'h0_1B;  8'h17: k = 9'h0_2C;
      8'h18: k = 9'h0_3C;  8'h19: k = 9'h0_2A;  8'h1A: k = 9'h0_1D;  8'h1B: k = 9'h0_22;
      8'h1C: k = 9'h0_35;  8'h1D: k = 9'h0_1A;
      8'h1E: k = 9'h0_16;  8'h1F: k = 9'h0_1E;  8'h20: k = 9'h0_26;  8'h21: k = 9'h0_25;
      8'h22: k = 9'h0_2E;  8'h23: k = 9'h0_36;  8'h24: k = 9'h0_3D;  8'h25: k = 9'h0_3E;
      8'h26: k = 9'h0_46;  8'h27: k = 9'h0_45;
      8'h28: k = 9'h0_5A;  8'h29: k = 9'h0_76;  8'h2A: k = 9'h0_66;  8'h2B: k = 9'h0_0D;
      8'h2C: k = 9'h0_29;  8'h2D: k = 9'h0_4E;  8'h2E: k = 9'h0_55;  8'h2F: k = 9'h0_54;
      8'h30: k = 9'h0_5B;  8'h31: k = 9'h0_5D;  8'h33: k = 9'h0_4C;  8'h34: k = 9'h0_52;
      8'h35: k = 9'h0_0E;  8'h36: k = 9'h0_41;  8'h37: k = 9'h0_49;  8'h38: k = 9'h0_4A;
      8'h39: k = 9'h0_58;
      8'h3A: k = 9'h0_05;  8'h3B: k = 9'h0_06;  8'h3C: k = 9'h0_04;  8'h3D: k = 9'h0_0C;
      8'h3E: k = 9'h0_03;  8'h3F: k = 9'h0_0B;  8'h40: k = 9'h0_83;  8'h41: k = 9'h0_0A;
      8'h42: k = 9'h0_01;  8'h43: k = 9'h0_09;  8'h44: k = 9'h0_78;  8'h45: k = 9'h0_07;
      8'h49: k = 9'h1_70;  8'h4A: k = 9'h1_6C;  8'h4B: k = 9'h1_7D;  8'h4C: k = 9'h1_71;
      8'h4D: k = 9'h1_69;  8'h4E: k = 9'h1_7A;  8'h4F: k = 9'h1_74;  8'h50: k = 9'h1_6B;
      8'h51: k = 9'h1_72;  8'h52: k = 9'h1_75;
      default: k = 9'h0_00;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/hid_kbd_scancode_fifo.sv
// Synchronous byte FIFO with show-ahead read data and a free-entry count.
module scancode_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign free    = (AW+1)'(DEPTH) - count;

endmodule

// File: rtl/hid_kbd_scancode.sv
// Translates HID boot keyboard reports into paced PS/2 set-2 make/break bytes.
// Define HID_KBD_TYPEMATIC_EN to add auto-repeat of the last held key.
module hid_kbd_scancode
  import hid_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int STROBE_GAP = 4,
  parameter int FREQ_HZ    = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] report_i,
  input  logic        report_valid_i,
  output logic [7:0]  code_o,
  output logic        strobe_o,
  output logic        err_o
);

  localparam int GAP_LOAD = (STROBE_GAP < 1) ? 1 : STROBE_GAP;
  localparam int GW       = $clog2(GAP_LOAD + 1);
  localparam int FW       = $clog2(FIFO_DEPTH) + 1;

  kbd_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d, item_last;
  logic [1:0] ph_q, ph_d, seq_last;
  logic       step;

  logic       pend_valid;
  kbd_rpt_t   pend_q, cur_q, prev_q;
  logic       consume, commit, roll_err, rollover;

  logic       item_emit, item_ext, item_brk;
  logic [7:0] item_code, item_usage, seq_byte;

  logic          fifo_push, fifo_pop, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [FW-1:0] fifo_free;
  logic [GW-1:0] gap_q;

  logic       rep_due;
  logic [7:0] rep_key;

  // Pending slot: last report wins; an overwrite of an unconsumed report is an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_q     <= '0;
      err_o      <= 1'b0;
    end else begin
      if (report_valid_i) begin
        pend_q     <= unpack_report(report_i);
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      err_o <= (report_valid_i && pend_valid && !consume) || roll_err;
    end
  end

  always_comb begin
    rollover = 1'b0;
    for (int i = 0; i < NUM_KEY_SLOTS; i++) begin
      if (cur_q.keys[i] == USAGE_ERR_ROLLOVER) rollover = 1'b1;
    end
  end

  // Decode what the current scan position would emit, if anything.
  always_comb begin
    ps2_key_t lut;
    lut        = '0;
    item_emit  = 1'b0;
    item_brk   = 1'b0;
    item_usage = '0;
    case (state_q)
      ST_MOD: begin
        lut       = modifier_to_ps2(idx_q);
        item_brk  = prev_q.mods[idx_q];
        item_emit = prev_q.mods[idx_q] != cur_q.mods[idx_q];
      end
      ST_BRK: begin
        item_usage = prev_q.keys[idx_q];
        lut        = usage_to_ps2(item_usage);
        item_brk   = 1'b1;
        item_emit  = (item_usage != 8'h00) && (lut.code != 8'h00) &&
                     !usage_in_report(item_usage, cur_q);
      end
      ST_MK: begin
        item_usage = cur_q.keys[idx_q];
        lut        = usage_to_ps2(item_usage);
        item_emit  = (item_usage != 8'h00) && (lut.code != 8'h00) &&
                     !usage_in_report(item_usage, prev_q);
      end
      ST_REP: begin
        item_usage = rep_key;
        lut        = usage_to_ps2(rep_key);
        item_emit  = lut.code != 8'h00;
      end
      default: ;
    endcase
    item_ext  = lut.ext;
    item_code = lut.code;
  end

  assign seq_last = {1'b0, item_ext} + {1'b0, item_brk};

  always_comb begin
    if (ph_q == 2'd0)      seq_byte = item_ext ? PS2_EXT : (item_brk ? PS2_BRK : item_code);
    else if (ph_q == 2'd1) seq_byte = (item_ext && item_brk) ? PS2_BRK : item_code;
    else                   seq_byte = item_code;
  end

  always_comb begin
    case (state_q)
      ST_MOD:  item_last = 3'd7;
      ST_REP:  item_last = 3'd0;
      default: item_last = 3'(NUM_KEY_SLOTS - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ph_q    <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      if (consume) cur_q  <= pend_q;
      if (commit)  prev_q <= cur_q;
    end
  end

  // A key sequence only starts with room for its longest form, so no byte is lost.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ph_d      = ph_q;
    fifo_push = 1'b0;
    consume   = 1'b0;
    commit    = 1'b0;
    roll_err  = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_valid) begin
          consume = 1'b1;
          state_d = ST_CHECK;
        end else if (rep_due) begin
          state_d = ST_REP;
          idx_d   = '0;
          ph_d    = '0;
        end
      end
      ST_CHECK: begin
        idx_d = '0;
        ph_d  = '0;
        if (rollover) begin
          roll_err = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_MOD;
        end
      end
      ST_MOD, ST_BRK, ST_MK, ST_REP: begin
        if (!item_emit) begin
          step = 1'b1;
        end else if (ph_q != 2'd0 || fifo_free >= FW'(3)) begin
          fifo_push = 1'b1;
          if (ph_q == seq_last) begin
            ph_d = '0;
            step = 1'b1;
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
        if (step) begin
          if (idx_q == item_last) begin
            idx_d = '0;
            case (state_q)
              ST_MOD:  state_d = ST_BRK;
              ST_BRK:  state_d = ST_MK;
              ST_MK:   state_d = ST_COMMIT;
              default: state_d = ST_IDLE;
            endcase
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef HID_KBD_TYPEMATIC_EN
  localparam int REP_DELAY = FREQ_HZ / 2;
  localparam int REP_RATE  = FREQ_HZ / 10;

  logic [31:0] rep_cnt;
  logic        rep_on, mk_seen;
  logic [7:0]  mk_key;
  logic        seq_done;

  assign seq_done = fifo_push && (ph_q == seq_last);
  assign rep_due  = rep_on && (rep_cnt == '0);

  // Timing restarts only when a new make occurs; releasing the key stops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= '0;
      rep_on  <= 1'b0;
      rep_key <= '0;
      mk_seen <= 1'b0;
      mk_key  <= '0;
    end else begin
      if (state_q == ST_CHECK) mk_seen <= 1'b0;
      else if (state_q == ST_MK && seq_done) begin
        mk_seen <= 1'b1;
        mk_key  <= item_usage;
      end
      if (commit && mk_seen) begin
        rep_on  <= 1'b1;
        rep_key <= mk_key;
        rep_cnt <= 32'(REP_DELAY - 1);
      end else if (commit && !usage_in_report(rep_key, cur_q)) begin
        rep_on <= 1'b0;
      end else if (state_q == ST_REP && seq_done) begin
        rep_cnt <= 32'(REP_RATE - 1);
      end else if (rep_on && rep_cnt != '0) begin
        rep_cnt <= rep_cnt - 32'd1;
      end
    end
  end
`else
  assign rep_due = 1'b0;
  assign rep_key = 8'h00;
`endif

  scancode_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (seq_byte),
    .pop       (fifo_pop),
    .rd_data   (fifo_rdata),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  // Gap counter of at least 1 keeps strobe_o from ever being high two cycles running.
  assign fifo_pop = !fifo_empty && (gap_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      code_o   <= 8'h00;
      strobe_o <= 1'b0;
      gap_q    <= '0;
    end else begin
      strobe_o <= fifo_pop;
      if (fifo_pop) begin
        code_o <= fifo_rdata;
        gap_q  <= GW'(GAP_LOAD);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/hid_kbd_scancode.md
HID_KBD_SCANCODE -- requirements
Module: hid_kbd_scancode

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, scancode FIFO entries (power of 2, >=4).
REQ-002 SHALL have parameter STROBE_GAP, default 4, idle cycles forced between consecutive strobe_o pulses.
REQ-003 SHALL have parameter FREQ_HZ, default 25_000_000, clk frequency used for typematic timing.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port report_i  input  64  HID boot keyboard report, already synchronous to clk; byte k = bits [8k+7:8k]; byte0 modifiers, byte1 reserved, bytes2..7 usages.
REQ-007 SHALL have port report_valid_i  input  1  one-cycle pulse qualifying report_i.
REQ-008 SHALL have port code_o  output  8  PS/2 set-2 byte, same meaning as the PS/2 keyboard decoder code output.
REQ-009 SHALL have port strobe_o  output  1  one-cycle pulse; code_o is valid in that cycle.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse on rollover report or dropped pending report.

Function
REQ-011 SHALL latch report_i on report_valid_i into a pending slot; a new pulse while the slot is occupied overwrites it (last wins) and pulses err_o.
REQ-012 SHALL run FSM IDLE -> CHECK -> MOD -> BRK -> MK -> COMMIT -> IDLE; IDLE leaves only when pending slot is occupied, consuming it.
REQ-013 CHECK: any usage byte == 8'h01 (ErrorRollOver) SHALL discard the report, pulse err_o, keep the previous report, return to IDLE.
REQ-014 MOD SHALL scan modifier bits 0..7 over 8 cycles; bit 1->0 emits break, 0->1 emits make.
REQ-015 BRK SHALL scan previous slots 2..7 and emit break for each nonzero usage absent from current slots; MK likewise emits make for each nonzero current usage absent from previous slots.
REQ-016 Each emitted key SHALL push [E0 if extended], [F0 if break], code, one byte per cycle, to the FIFO.
REQ-017 Before pushing a key sequence the FSM SHALL stall until >=3 FIFO entries are free; no byte is ever dropped.
REQ-018 Usages with no table entry (code 8'h00) and usage 8'h00 SHALL be skipped without pushing.
REQ-019 Modifier codes SHALL be: LCtrl 14, LShift 12, LAlt 11, LGUI E0 1F, RCtrl E0 14, RShift 59, RAlt E0 11, RGUI E0 27.
REQ-020 COMMIT SHALL copy current report into previous report.
REQ-021 Output stage SHALL pop one byte when FIFO non-empty and gap counter zero, asserting strobe_o next cycle with code_o; gap counter then loads STROBE_GAP.
REQ-022 code_o SHALL hold its last value between strobes; strobe_o never high two consecutive cycles.
REQ-023 Simultaneous push and pop on a full FIFO SHALL NOT occur (guaranteed by REQ-017); simultaneous push/pop otherwise keeps count unchanged.

Reset
REQ-024 On reset: code_o=0, strobe_o=0, err_o=0, FSM IDLE, FIFO empty, pending slot empty, previous report all zero, gap counter 0, typematic timers 0.
REQ-025 Reset mid-sequence SHALL abort without emitting any remaining or queued byte.

Configuration
REQ-026 With HID_KBD_TYPEMATIC_EN defined: the last made non-modifier key, while still held, SHALL re-push its make sequence after 500 ms, then every 100 ms (FREQ_HZ-derived counts); any new report cancels and restarts timing only if that key changes.
REQ-027 Without HID_KBD_TYPEMATIC_EN: no repeat logic is synthesized; codes emitted only on report changes.

Structure
REQ-028 Package hid_kbd_pkg SHALL hold report byte offsets, PS2_EXT=8'hE0, PS2_BRK=8'hF0, ErrorRollOver constant, and the usage-to-{extended,code} lookup function.
REQ-029 Sub-module scancode_fifo (synchronous FIFO, parameter depth, free-count output) SHALL hold queued bytes.

Verification
REQ-030 report 64'h0000_0000_0004_0000 then all-zero -> strobes 1C, then F0, 1C.
REQ-031 report byte0=8'h10 then all-zero -> E0 14, then E0 F0 14.
REQ-032 report with byte2=8'h01 -> single err_o pulse, no strobe, next zero report emits nothing.
REQ-033 keys 04,05,06 pressed in one report, STROBE_GAP=4 -> 1C 32 21, strobe pulses >=5 cycles apart.
REQ-034 reset asserted after first strobe of REQ-033 -> no further strobe, following all-zero report emits nothing.
REQ-035 HID_KBD_TYPEMATIC_EN, FREQ_HZ=1000, hold 04 -> 1C at t0, again at +500 cycles, then every 100 cycles until release emits F0 1C.
